// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared state type and defaults for the serial frame emitter
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PARITY,
    GAP
  } tx_state_t;

  localparam int         DEF_CLK_DIV   = 4166667;
  localparam logic [7:0] DEF_SYNC_WORD = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_tick_gen.sv
// rtl/serial_frame_tx_bit_tick_gen.sv - free-running divider producing one tick per bit period
module bit_tick_gen
  import serial_frame_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic Clk,
  input  logic Rst_n,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - framed LSB-first serial emitter with ADC sample-hold control
// Optional per-word even parity bit: define SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEF_SYNC_WORD),
  parameter int                CLK_DIV   = DEF_CLK_DIV,
  parameter int                WORDS     = 1,
  parameter int                GAP_BITS  = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Enable,
  input  logic [DATA_W-1:0] in,
  output logic              Hold,
  output logic              Serial_Bit_Out,
  output logic              Busy,
  output logic              Frame_Start
);

  localparam int BCW = $clog2(max3(SYNC_W, DATA_W, GAP_BITS) + 1);
  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SHW = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;

  logic           tick;
  tx_state_t      state_q, state_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic [WCW-1:0] word_q, word_d;
  logic [SHW-1:0] sh_q, sh_d;
  logic           line_d, hold_d, busy_d, fs_d;
  logic           word_done, frame_done, load_word;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .tick (tick)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q        <= IDLE;
      bit_q          <= '0;
      word_q         <= '0;
      sh_q           <= '0;
      Serial_Bit_Out <= 1'b0;
      Hold           <= 1'b0;
      Busy           <= 1'b0;
      Frame_Start    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bit_q          <= bit_d;
      word_q         <= word_d;
      sh_q           <= sh_d;
      Serial_Bit_Out <= line_d;
      Hold           <= hold_d;
      Busy           <= busy_d;
      Frame_Start    <= fs_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q          <= par_d;
`endif
    end
  end

  // Sync and data share one shift register; the transmitted bit is always its LSB.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    word_d     = word_q;
    sh_d       = sh_q;
    line_d     = Serial_Bit_Out;
    hold_d     = Hold;
    busy_d     = Busy;
    fs_d       = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    load_word  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_d      = par_q;
`endif
    if (tick) begin
      case (state_q)
        SYNC: begin
          if (bit_q == BCW'(SYNC_W - 1)) begin
            load_word = 1'b1;
            word_d    = '0;
          end else begin
            bit_d  = bit_q + BCW'(1);
            sh_d   = sh_q >> 1;
            line_d = sh_d[0];
            hold_d = (bit_d == BCW'(SYNC_W - 1));
          end
        end
        DATA: begin
          if (bit_q == BCW'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_d = PARITY;
            line_d  = par_q;
`else
            word_done = 1'b1;
`endif
          end else begin
            bit_d  = bit_q + BCW'(1);
            sh_d   = sh_q >> 1;
            line_d = sh_d[0];
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: word_done = 1'b1;
`endif
        GAP: begin
          if (bit_q == BCW'(GAP_BITS - 1)) frame_done = 1'b1;
          else bit_d = bit_q + BCW'(1);
        end
        default: frame_done = 1'b1;
      endcase
    end

    if (word_done) begin
      if (int'(word_q) < WORDS - 1) begin
        load_word = 1'b1;
        word_d    = word_q + WCW'(1);
      end else if (GAP_BITS > 0) begin
        state_d = GAP;
        bit_d   = '0;
        line_d  = 1'b0;
        hold_d  = 1'b0;
      end else begin
        frame_done = 1'b1;
      end
    end

    if (load_word) begin
      state_d = DATA;
      bit_d   = '0;
      sh_d    = SHW'(in);
      line_d  = in[0];
      hold_d  = 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_d   = ^in;
`endif
    end

    // End of frame chains straight into the next sync word while Enable is held.
    if (frame_done) begin
      bit_d  = '0;
      word_d = '0;
      if (Enable) begin
        state_d = SYNC;
        sh_d    = SHW'(SYNC_WORD);
        line_d  = SYNC_WORD[0];
        hold_d  = (SYNC_W == 1);
        busy_d  = 1'b1;
        fs_d    = 1'b1;
      end else begin
        state_d = IDLE;
        line_d  = 1'b0;
        hold_d  = 1'b0;
        busy_d  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx (two parameter sets)
module tb_serial_frame_tx;

  localparam int CD = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int DW = 9;
`else
  localparam int DW = 8;
`endif
  localparam int NBA = 8 + DW;
  localparam int NBB = 8 + 2 * DW + 2;
  localparam logic [7:0] SYNC_PAT = 8'hA5;

  typedef struct packed {logic line; logic hold; logic first;} exp_t;
  typedef struct packed {logic [3:0] line; logic [3:0] hold; logic [3:0] busy; logic [3:0] fs;} obs_t;

  logic Clk = 1'b0, Rst_n = 1'b0, en_a = 1'b0, en_b = 1'b0, sel = 1'b0;
  logic [7:0] in_a = 8'h00, in_b = 8'h00;
  logic hold_a, line_a, busy_a, fs_a, hold_b, line_b, busy_b, fs_b;
  logic hold_s, line_s, busy_s, fs_s;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   wait_cyc, fs_cyc;
  logic got_start;

  serial_frame_tx #(.DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'hA5), .CLK_DIV(CD), .WORDS(1), .GAP_BITS(0)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(en_a), .in(in_a),
    .Hold(hold_a), .Serial_Bit_Out(line_a), .Busy(busy_a), .Frame_Start(fs_a));

  serial_frame_tx #(.DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'hA5), .CLK_DIV(CD), .WORDS(2), .GAP_BITS(2)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(en_b), .in(in_b),
    .Hold(hold_b), .Serial_Bit_Out(line_b), .Busy(busy_b), .Frame_Start(fs_b));

  assign hold_s = sel ? hold_b : hold_a;
  assign line_s = sel ? line_b : line_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign fs_s   = sel ? fs_b   : fs_a;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic push_frame(input logic [7:0] w0, input logic [7:0] w1, input int nw, input int gap);
    exp_t e;
    logic [7:0] sw, d;
    sw = SYNC_PAT;
    for (int i = 0; i < 8; i++) begin
      e.line = sw[i]; e.hold = (i == 7); e.first = (i == 0); exp_q.push_back(e);
    end
    for (int w = 0; w < nw; w++) begin
      d = (w == 0) ? w0 : w1;
      for (int i = 0; i < 8; i++) begin
        e.line = d[i]; e.hold = 1'b1; e.first = 1'b0; exp_q.push_back(e);
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      e.line = ^d; e.hold = 1'b1; e.first = 1'b0; exp_q.push_back(e);
`endif
    end
    for (int g = 0; g < gap; g++) begin
      e = '0; exp_q.push_back(e);
    end
  endtask

  // Waits (bounded) for Frame_Start, then records CD samples per bit; w1/w2 are applied after each capture.
  task automatic collect_frame(input int nbits, input logic keep_en, input logic [7:0] w1, input logic [7:0] w2);
    obs_t o;
    got_start = 1'b0;
    wait_cyc  = 0;
    while (!got_start && wait_cyc < 200) begin
      @(negedge Clk);
      if (fs_s === 1'b1) got_start = 1'b1;
      else wait_cyc++;
    end
    if (sel) en_b = keep_en; else en_a = keep_en;
    if (!got_start) return;
    fs_cyc = cyc;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CD; c++) begin
        if (!(b == 0 && c == 0)) @(negedge Clk);
        o.line[c] = line_s; o.hold[c] = hold_s; o.busy[c] = busy_s; o.fs[c] = fs_s;
        if (c == 0 && b == 8)      begin if (sel) in_b = w1; else in_a = w1; end
        if (c == 0 && b == 8 + DW) begin if (sel) in_b = w2; else in_a = w2; end
      end
      obs_q.push_back(o);
    end
  endtask

  task automatic test_reset();
    int k;
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({line_a, hold_a, busy_a, fs_a} !== 4'b0000) begin
      n_err++; $display("FAIL reset_a line/hold/busy/fs got %b required 0000", {line_a, hold_a, busy_a, fs_a});
    end
    n_cmp++;
    if ({line_b, hold_b, busy_b, fs_b} !== 4'b0000) begin
      n_err++; $display("FAIL reset_b line/hold/busy/fs got %b required 0000", {line_b, hold_b, busy_b, fs_b});
    end
    Rst_n = 1'b1;
    k = 0;
    repeat (12) begin
      @(negedge Clk);
      if ({line_a, hold_a, busy_a, fs_a, line_b, hold_b, busy_b, fs_b} !== 8'h00) k++;
    end
    n_cmp++;
    if (k !== 0) begin n_err++; $display("FAIL idle_quiet active samples got %0d required 0", k); end
  endtask

  task automatic test_basic_frame();
    exp_t e; obs_t o; int k;
    sel = 1'b0; exp_q.delete(); obs_q.delete();
    in_a = 8'h3C;
    push_frame(8'h3C, 8'h00, 1, 0);
    en_a = 1'b1;
    collect_frame(NBA, 1'b0, 8'hFF, 8'hFF);
    n_cmp++;
    if (!got_start || wait_cyc > CD - 1) begin
      n_err++; $display("FAIL basic_latency start=%0b wait=%0d required start=1 wait<=%0d", got_start, wait_cyc, CD - 1);
    end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.line !== {4{e.line}} || o.hold !== {4{e.hold}} || o.busy !== 4'hF || o.fs !== {3'b000, e.first}) begin
        n_err++;
        $display("FAIL basic bit%0d line/hold/busy/fs got %h/%h/%h/%h required %h/%h/f/%h",
                 k, o.line, o.hold, o.busy, o.fs, {4{e.line}}, {4{e.hold}}, {3'b000, e.first});
      end
      k++;
    end
    @(negedge Clk);
    n_cmp++;
    if ({busy_a, line_a, hold_a, fs_a} !== 4'b0000) begin
      n_err++; $display("FAIL basic_idle busy/line/hold/fs got %b required 0000", {busy_a, line_a, hold_a, fs_a});
    end
  endtask

  task automatic test_hold_window();
    exp_t e; obs_t o; int k;
    sel = 1'b0; exp_q.delete(); obs_q.delete();
    in_a = 8'h5A;
    push_frame(8'h5A, 8'h00, 1, 0);
    en_a = 1'b1;
    collect_frame(NBA, 1'b0, 8'hFF, 8'hFF);
    n_cmp++;
    if (obs_q.size() != NBA) begin
      n_err++; $display("FAIL hold_frame bits got %0d required %0d", obs_q.size(), NBA);
    end else begin
      n_cmp += 2;
      if (obs_q[6].hold !== 4'h0) begin n_err++; $display("FAIL hold_sync6 got %h required 0", obs_q[6].hold); end
      if (obs_q[7].hold !== 4'hF) begin n_err++; $display("FAIL hold_sync7 got %h required f", obs_q[7].hold); end
    end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.line !== {4{e.line}} || o.hold !== {4{e.hold}} || o.busy !== 4'hF) begin
        n_err++;
        $display("FAIL hold bit%0d line/hold/busy got %h/%h/%h required %h/%h/f", k, o.line, o.hold, o.busy, {4{e.line}}, {4{e.hold}});
      end
      k++;
    end
    @(negedge Clk);
    n_cmp++;
    if (hold_a !== 1'b0) begin n_err++; $display("FAIL hold_fall got %b required 0", hold_a); end
  endtask

  task automatic test_multi_word();
    exp_t e; obs_t o; int k;
    sel = 1'b1; exp_q.delete(); obs_q.delete();
    in_b = 8'h01;
    push_frame(8'h01, 8'h80, 2, 2);
    en_b = 1'b1;
    collect_frame(NBB, 1'b0, 8'h80, 8'hFF);
    n_cmp++;
    if (!got_start) begin n_err++; $display("FAIL multi_start got 0 required 1"); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.line !== {4{e.line}} || o.hold !== {4{e.hold}} || o.busy !== 4'hF || o.fs !== {3'b000, e.first}) begin
        n_err++;
        $display("FAIL multi bit%0d line/hold/busy/fs got %h/%h/%h/%h required %h/%h/f/%h",
                 k, o.line, o.hold, o.busy, o.fs, {4{e.line}}, {4{e.hold}}, {3'b000, e.first});
      end
      k++;
    end
    @(negedge Clk);
    n_cmp++;
    if ({busy_b, line_b, hold_b} !== 3'b000) begin
      n_err++; $display("FAIL multi_idle busy/line/hold got %b required 000", {busy_b, line_b, hold_b});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o; int k, first_fs;
    sel = 1'b1; exp_q.delete(); obs_q.delete();
    in_b = 8'h11;
    push_frame(8'h11, 8'h22, 2, 2);
    push_frame(8'h33, 8'h44, 2, 2);
    en_b = 1'b1;
    collect_frame(NBB, 1'b1, 8'h22, 8'h33);
    first_fs = fs_cyc;
    n_cmp++;
    if (!got_start) begin n_err++; $display("FAIL b2b_start1 got 0 required 1"); end
    collect_frame(NBB, 1'b0, 8'h44, 8'h00);
    n_cmp++;
    if (!got_start || wait_cyc !== 0) begin
      n_err++; $display("FAIL b2b_no_idle start=%0b wait=%0d required start=1 wait=0", got_start, wait_cyc);
    end
    n_cmp++;
    if (fs_cyc - first_fs !== NBB * CD) begin
      n_err++; $display("FAIL b2b_period got %0d required %0d", fs_cyc - first_fs, NBB * CD);
    end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.line !== {4{e.line}} || o.hold !== {4{e.hold}} || o.busy !== 4'hF || o.fs !== {3'b000, e.first}) begin
        n_err++;
        $display("FAIL b2b bit%0d line/hold/busy/fs got %h/%h/%h/%h required %h/%h/f/%h",
                 k, o.line, o.hold, o.busy, o.fs, {4{e.line}}, {4{e.hold}}, {3'b000, e.first});
      end
      k++;
    end
    @(negedge Clk);
    n_cmp++;
    if (busy_b !== 1'b0) begin n_err++; $display("FAIL b2b_idle busy got %b required 0", busy_b); end
  endtask

`ifdef SERIAL_FRAME_TX_PARITY_EN
  task automatic test_parity();
    exp_t e; obs_t o; logic [7:0] vals [2];
    vals[0] = 8'h07; vals[1] = 8'h3C;
    sel = 1'b0;
    for (int v = 0; v < 2; v++) begin
      exp_q.delete(); obs_q.delete();
      in_a = vals[v];
      push_frame(vals[v], 8'h00, 1, 0);
      en_a = 1'b1;
      collect_frame(NBA, 1'b0, 8'hFF, 8'hFF);
      n_cmp++;
      if (obs_q.size() != NBA) begin
        n_err++; $display("FAIL parity_frame%0d bits got %0d required %0d", v, obs_q.size(), NBA);
      end else if (obs_q[NBA-1].line !== {4{^vals[v]}}) begin
        n_err++; $display("FAIL parity_%h got %h required %h", vals[v], obs_q[NBA-1].line, {4{^vals[v]}});
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o.line !== {4{e.line}} || o.hold !== {4{e.hold}}) begin
          n_err++; $display("FAIL parity_bits line/hold got %h/%h required %h/%h", o.line, o.hold, {4{e.line}}, {4{e.hold}});
        end
      end
      @(negedge Clk);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    exp_t e; obs_t o; int k;
    sel = 1'b0; exp_q.delete(); obs_q.delete();
    in_a = 8'h3C; en_a = 1'b1;
    k = 0;
    do begin @(negedge Clk); k++; end while (fs_a !== 1'b1 && k < 200);
    en_a = 1'b0;
    repeat ((8 + 3) * CD) @(negedge Clk);
    n_cmp++;
    if ({busy_a, line_a} !== 2'b11) begin
      n_err++; $display("FAIL rst_data3 busy/line got %b required 11", {busy_a, line_a});
    end
    Rst_n = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({line_a, hold_a, busy_a, fs_a} !== 4'b0000) begin
      n_err++; $display("FAIL rst_abort line/hold/busy/fs got %b required 0000", {line_a, hold_a, busy_a, fs_a});
    end
    Rst_n = 1'b1;
    k = 0;
    repeat (40) begin @(negedge Clk); if ({busy_a, fs_a, line_a} !== 3'b000) k++; end
    n_cmp++;
    if (k !== 0) begin n_err++; $display("FAIL rst_no_resume active samples got %0d required 0", k); end
    in_a = 8'h96;
    push_frame(8'h96, 8'h00, 1, 0);
    en_a = 1'b1;
    collect_frame(NBA, 1'b0, 8'hFF, 8'hFF);
    n_cmp++;
    if (!got_start) begin n_err++; $display("FAIL rst_restart got 0 required 1"); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.line !== {4{e.line}} || o.hold !== {4{e.hold}} || o.fs !== {3'b000, e.first}) begin
        n_err++;
        $display("FAIL rst_frame bit%0d line/hold/fs got %h/%h/%h required %h/%h/%h",
                 k, o.line, o.hold, o.fs, {4{e.line}}, {4{e.hold}}, {3'b000, e.first});
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hold_window();
    test_multi_word();
    test_back_to_back();
`ifdef SERIAL_FRAME_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
